fft_mux_tree: RTL and testbench

//  Parametrised, pipelined NUM_INPUTS:1 selector for the FFT core: a tree of RADIX-way

---
 rtl/fft_mux_tree_if.sv | 25 ++
 rtl/fft_mux_tree.sv | 93 +++++++++
 tb/tb_fft_mux_tree.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/fft_mux_tree_if.sv
// fft_mux_tree_if: select/sweep control, parallel frame input and serial sample output of the FFT mux tree
interface fft_mux_tree_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_INPUTS = 2048
);
  localparam int SEL_W = $clog2(NUM_INPUTS);
  logic                  mode_i;
  logic                  start_i;
  logic                  valid_i;
  logic [SEL_W-1:0]      sel_i;
  logic [DATA_WIDTH-1:0] data_i [NUM_INPUTS];
  logic [DATA_WIDTH-1:0] data_o;
  logic                  valid_o;
  logic [SEL_W-1:0]      sel_o;
  logic                  last_o;
  logic                  busy_o;
  modport master (
    output mode_i, start_i, valid_i, sel_i, data_i,
    input  data_o, valid_o, sel_o, last_o, busy_o
  );
  modport slave (
    input  mode_i, start_i, valid_i, sel_i, data_i,
    output data_o, valid_o, sel_o, last_o, busy_o
  );
endinterface

// File: rtl/fft_mux_tree.sv
// fft_mux_tree: pipelined NUM_INPUTS:1 selector built from RADIX-way registered mux stages,
// fed by an external index or by an auto-sweep that serialises the whole frame.
module fft_mux_tree #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_INPUTS = 2048,
  parameter int RADIX      = 16
) (
  input logic          clk,
  input logic          rst,
  fft_mux_tree_if.slave bus
);
  localparam int SEL_W  = $clog2(NUM_INPUTS);
  localparam int LVL_W  = $clog2(RADIX);
  localparam int STAGES = (SEL_W + LVL_W - 1) / LVL_W;
  if (NUM_INPUTS < 2 || (NUM_INPUTS & (NUM_INPUTS - 1)) != 0) begin : g_bad_n
    $error("fft_mux_tree: NUM_INPUTS must be a power of two >= 2");
  end
  if (RADIX < 2 || (RADIX & (RADIX - 1)) != 0) begin : g_bad_r
    $error("fft_mux_tree: RADIX must be a power of two >= 2");
  end
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t           state_q, state_d;
  logic [SEL_W-1:0] cnt_q, cnt_d, nxt, iss_idx;
  logic             go, iss_v, iss_l;
  always_comb begin
    nxt     = cnt_q + 1'b1;
    go      = state_q == IDLE && bus.mode_i && bus.start_i;
    iss_v   = go || state_q == SWEEP || (state_q == IDLE && !bus.mode_i && bus.valid_i);
    iss_idx = go ? '0 : state_q == SWEEP ? nxt : bus.sel_i;
    iss_l   = state_q == SWEEP && &nxt;
    state_d = go ? SWEEP : iss_l ? IDLE : state_q;
    cnt_d   = go ? '0 : state_q == SWEEP ? nxt : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // Each stage consumes its slice of the index; the full index, valid and last ride along.
  for (genvar s = 1; s <= STAGES; s++) begin : g_st
    localparam int LO  = (s - 1) * LVL_W;
    localparam int HI  = s * LVL_W > SEL_W ? SEL_W : s * LVL_W;
    localparam int W   = HI - LO;
    localparam int IN  = NUM_INPUTS >> LO;
    localparam int OUT = NUM_INPUTS >> HI;
    localparam int IW  = $clog2(IN);
    logic [DATA_WIDTH-1:0] in_w [IN];
    logic [SEL_W-1:0]      idx_in, idx_q, idx_d;
    logic                  v_in, l_in, v_q, v_d, l_q, l_d;
    logic [DATA_WIDTH-1:0] d_q [OUT];
    logic [DATA_WIDTH-1:0] d_d [OUT];
    if (s == 1) begin : g_in
      assign in_w   = bus.data_i;
      assign idx_in = iss_idx;
      assign v_in   = iss_v;
      assign l_in   = iss_l;
    end else begin : g_in
      assign in_w   = g_st[s-1].d_q;
      assign idx_in = g_st[s-1].idx_q;
      assign v_in   = g_st[s-1].v_q;
      assign l_in   = g_st[s-1].l_q;
    end
    always_comb begin
      for (int j = 0; j < OUT; j++)
        d_d[j] = v_in ? in_w[IW'(j << W) | IW'(idx_in[LO +: W])] : d_q[j];
      idx_d = v_in ? idx_in : idx_q;
      v_d   = v_in;
      l_d   = v_in && l_in;
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j < OUT; j++) d_q[j] <= '0;
        idx_q <= '0;
        v_q   <= 1'b0;
        l_q   <= 1'b0;
      end else begin
        d_q   <= d_d;
        idx_q <= idx_d;
        v_q   <= v_d;
        l_q   <= l_d;
      end
    end
  end
  assign bus.data_o  = g_st[STAGES].d_q[0];
  assign bus.sel_o   = g_st[STAGES].idx_q;
  assign bus.valid_o = g_st[STAGES].v_q;
  assign bus.last_o  = g_st[STAGES].l_q;
  assign bus.busy_o  = state_q == SWEEP;
endmodule

// File: tb/tb_fft_mux_tree.sv
// tb_fft_mux_tree: scoreboard bench for the default tree plus direct checks of 1-stage and 3-stage variants
module tb_fft_mux_tree;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0, total = 0, bad = 0, t0, t1;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  fft_mux_tree_if #(.DATA_WIDTH(8), .NUM_INPUTS(2048)) b0 ();
  fft_mux_tree_if #(.DATA_WIDTH(8), .NUM_INPUTS(8))    b1 ();
  fft_mux_tree_if #(.DATA_WIDTH(8), .NUM_INPUTS(32))   b2 ();
  fft_mux_tree #(.DATA_WIDTH(8), .NUM_INPUTS(2048), .RADIX(16)) u0 (.clk(clk), .rst(rst), .bus(b0));
  fft_mux_tree #(.DATA_WIDTH(8), .NUM_INPUTS(8),    .RADIX(8))  u1 (.clk(clk), .rst(rst), .bus(b1));
  fft_mux_tree #(.DATA_WIDTH(8), .NUM_INPUTS(32),   .RADIX(4))  u2 (.clk(clk), .rst(rst), .bus(b2));
  typedef struct {logic [7:0] d; logic [10:0] s; logic l; int c;} exp_t;
  typedef struct {logic [10:0] s; logic [7:0] seed; logic [7:0] d;} vec_t;
  exp_t q[$];
  exp_t me;
  vec_t tab[6];
  function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %0h want %0h", n, cyc, a, e);
    end
  endfunction
  task automatic set_data0(input logic [7:0] seed);
    for (int k = 0; k < 2048; k++) b0.data_i[k] = 8'(k) ^ seed;
  endtask
  task automatic set_small(input logic [7:0] seed);
    for (int k = 0; k < 8; k++) b1.data_i[k] = 8'(k) ^ seed;
    for (int k = 0; k < 32; k++) b2.data_i[k] = 8'(k) ^ seed;
  endtask
  always @(negedge clk) begin
    if (b0.valid_o) begin
      if (q.size() == 0) chk("extra_out", 32'(b0.valid_o), 0);
      else begin
        me = q.pop_front();
        chk("data", 32'(b0.data_o), 32'(me.d));
        chk("sel", 32'(b0.sel_o), 32'(me.s));
        chk("last", 32'(b0.last_o), 32'(me.l));
        chk("latency", cyc, me.c);
      end
    end else if (b0.last_o) chk("last_idle", 32'(b0.last_o), 0);
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: cyc=%0d want finish", cyc);
    $fatal(1);
  end
  initial begin
    tab[0] = '{11'h000, 8'h5A, 8'h5A};
    tab[1] = '{11'h001, 8'h33, 8'h32};
    tab[2] = '{11'h7FF, 8'hC3, 8'h3C};
    tab[3] = '{11'h400, 8'h11, 8'h11};
    tab[4] = '{11'h00F, 8'h0F, 8'h00};
    tab[5] = '{11'h010, 8'hA0, 8'hB0};
    {b0.mode_i, b0.start_i, b0.valid_i, b0.sel_i} = '0;
    {b1.mode_i, b1.start_i, b1.valid_i, b1.sel_i} = '0;
    {b2.mode_i, b2.start_i, b2.valid_i, b2.sel_i} = '0;
    set_small(8'h5A);
    // reset with random activity on the inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b0.mode_i = 1'($urandom); b0.start_i = 1'($urandom);
      b0.valid_i = 1'($urandom); b0.sel_i = 11'($urandom);
      set_data0(8'($urandom));
      chk("rst_data", 32'(b0.data_o), 0);
      chk("rst_valid", 32'(b0.valid_o), 0);
      chk("rst_busy", 32'(b0.busy_o), 0);
      chk("rst_last", 32'(b0.last_o), 0);
    end
    @(negedge clk);
    chk("rst_valid_end", 32'(b0.valid_o), 0);
    rst = 1'b0;
    {b0.mode_i, b0.start_i, b0.valid_i, b0.sel_i} = '0;
    set_data0(8'h5A);
    repeat (2) @(negedge clk);
    // single external select of the top index
    b0.sel_i = 11'h7FF; b0.valid_i = 1'b1; t0 = cyc;
    q.push_back('{8'hA5, 11'h7FF, 1'b0, cyc + 3});
    @(negedge clk);
    b0.valid_i = 1'b0; set_data0(8'h00);
    repeat (3) @(negedge clk);
    chk("hold_cyc", cyc, t0 + 4);
    chk("hold_valid", 32'(b0.valid_o), 0);
    chk("hold_data", 32'(b0.data_o), 32'h A5);
    chk("hold_sel", 32'(b0.sel_o), 32'h7FF);
    // back-to-back external stream, data changing every cycle
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      set_data0(tab[i].seed);
      b0.sel_i = tab[i].s; b0.valid_i = 1'b1;
      q.push_back('{tab[i].d, tab[i].s, 1'b0, cyc + 3});
    end
    @(negedge clk);
    b0.valid_i = 1'b0; set_data0(8'hFF);
    repeat (5) @(negedge clk);
    chk("stream_drain", q.size(), 0);
    set_data0(8'h5A);
    // full sweep, with start/valid/mode noise that must be ignored
    @(negedge clk);
    b0.mode_i = 1'b1; b0.start_i = 1'b1; t0 = cyc;
    for (int k = 0; k < 2048; k++) q.push_back('{8'(k) ^ 8'h5A, 11'(k), k == 2047, t0 + 3 + k});
    for (int c = 1; c <= 2048; c++) begin
      @(negedge clk);
      chk("sweep_busy", 32'(b0.busy_o), 32'(c <= 2047));
      b0.start_i = 1'($urandom); b0.mode_i = 1'($urandom);
      b0.valid_i = 1'($urandom); b0.sel_i = 11'($urandom);
      if (c == 2048) begin
        // restart right after busy falls, with a competing external strobe
        b0.mode_i = 1'b1; b0.start_i = 1'b1; b0.valid_i = 1'b1; t1 = cyc;
        for (int k = 0; k < 2048; k++) q.push_back('{8'(k) ^ 8'h5A, 11'(k), k == 2047, t1 + 3 + k});
      end
    end
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      b0.start_i = 1'($urandom); b0.mode_i = 1'($urandom);
      b0.valid_i = 1'($urandom); b0.sel_i = 11'($urandom);
    end
    rst = 1'b1;
    while (q.size() != 0 && q[$].c > t1 + 100) void'(q.pop_back());
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_valid", 32'(b0.valid_o), 0);
      chk("abort_last", 32'(b0.last_o), 0);
      chk("abort_busy", 32'(b0.busy_o), 0);
    end
    rst = 1'b0;
    {b0.mode_i, b0.start_i, b0.valid_i, b0.sel_i} = '0;
    repeat (5) @(negedge clk);
    chk("sweep_drain", q.size(), 0);
    // small variants: one external select each
    b1.sel_i = 3'd6; b1.valid_i = 1'b1;
    b2.sel_i = 5'd21; b2.valid_i = 1'b1; t0 = cyc;
    @(negedge clk);
    b1.valid_i = 1'b0; b2.valid_i = 1'b0; set_small(8'h00);
    chk("n8_valid", 32'(b1.valid_o), 1);
    chk("n8_data", 32'(b1.data_o), 32'(8'd6 ^ 8'h5A));
    chk("n8_sel", 32'(b1.sel_o), 6);
    chk("n32_early", 32'(b2.valid_o), 0);
    @(negedge clk);
    chk("n8_off", 32'(b1.valid_o), 0);
    chk("n32_early2", 32'(b2.valid_o), 0);
    @(negedge clk);
    chk("n32_cyc", cyc, t0 + 3);
    chk("n32_valid", 32'(b2.valid_o), 1);
    chk("n32_data", 32'(b2.data_o), 32'(8'd21 ^ 8'h5A));
    chk("n32_sel", 32'(b2.sel_o), 21);
    // small variants: full sweeps
    set_small(8'h5A);
    @(negedge clk);
    b1.mode_i = 1'b1; b1.start_i = 1'b1;
    b2.mode_i = 1'b1; b2.start_i = 1'b1;
    @(negedge clk);
    b1.start_i = 1'b0; b2.start_i = 1'b0;
    for (int c = 1; c <= 38; c++) begin
      if (c > 1) @(negedge clk);
      chk("n8_sw_valid", 32'(b1.valid_o), 32'(c >= 1 && c <= 8));
      if (c >= 1 && c <= 8) begin
        chk("n8_sw_sel", 32'(b1.sel_o), c - 1);
        chk("n8_sw_data", 32'(b1.data_o), 32'(8'(c - 1) ^ 8'h5A));
        chk("n8_sw_last", 32'(b1.last_o), 32'(c == 8));
      end
      chk("n32_sw_valid", 32'(b2.valid_o), 32'(c >= 3 && c <= 34));
      if (c >= 3 && c <= 34) begin
        chk("n32_sw_sel", 32'(b2.sel_o), c - 3);
        chk("n32_sw_data", 32'(b2.data_o), 32'(8'(c - 3) ^ 8'h5A));
        chk("n32_sw_last", 32'(b2.last_o), 32'(c == 34));
      end
    end
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
